trig_frame_formatter: RTL and testbench
=======================================

TRIG_FRAME_FORMATTER -- requirements
Module: trig_frame_formatter

Interface
REQ-001 SHALL have clock: clk_160  input  1  160 MHz fabric clock, 4 cycles per BX; all logic in this single domain.
REQ-002 SHALL have reset: reset_n  input  1  asynchronous assert, active-low.
REQ-003 SHALL have gem_data  input  56  packed clusters {cluster3..cluster0}, each 14 bits.
REQ-004 SHALL have gem_overflow  input  1  cluster overflow flag for the same BX.
REQ-005 SHALL have frame_sync  input  1  single-cycle pulse that realigns the frame phase.
REQ-006 SHALL have ena_test_pat  input  1  high: send PRBS-7 instead of gem_data.
REQ-007 SHALL have inj_err  input  1  rising edge: corrupt one bit of the next frame.
REQ-008 SHALL have tx_data  output  16  word to the GTX TX data port.
REQ-009 SHALL have tx_isk  output  2  per-byte K-character flags for tx_data.
REQ-010 SHALL have ltncy_trig  output  1  one-cycle pulse coincident with word0 of each marker frame.
REQ-011 SHALL have strt_ltncy  output  1  one-cycle pulse on the first marker frame after reset.
REQ-012 SHALL have parameter MARKER_PERIOD, default 128, frames between latency markers (power of 2).

Function
REQ-013 SHALL keep a 2-bit phase counter, 0..3, incrementing every cycle and wrapping 3->0.
REQ-014 SHALL treat a "load edge" as any edge where phase==3 or frame_sync==1; phase SHALL be 0 after every load edge.
REQ-015 SHALL, on a load edge, capture gem_data (or PRBS) and gem_overflow into the frame register, and advance the marker counter.
REQ-016 SHALL drive tx_data/tx_isk as registered outputs: after a load edge, word0..word3 of the newly loaded frame on the next 4 cycles; 1-cycle latency from sample to word0.
REQ-017 SHALL use this frame word layout: word0={K,d[7:0]}, word1=d[23:8], word2=d[39:24], word3=d[55:40].
REQ-018 SHALL set tx_isk=2'b10 on word0 and 2'b00 on words 1-3.
REQ-019 SHALL select K by priority: marker frame (marker counter==0) -> 8'hFC; else overflow -> 8'hF7; else 8'hBC.
REQ-020 SHALL, when overflow coincides with a marker frame, hold overflow pending and report it as F7 on the following frame; this applies unless that following frame is itself a marker.
REQ-021 SHALL, with ena_test_pat high at a load edge, fill d[55:0] with the next 56 bits of PRBS-7 (x^7+x^6+1, seed 7'h7F), with the LFSR advancing 56 steps per frame; while ena_test_pat is low, the LFSR SHALL hold its state.
REQ-022 SHALL latch each inj_err rising edge as pending; the next loaded frame SHALL have d[0] inverted and pending cleared; multiple edges within one frame SHALL yield one error.
REQ-023 SHALL truncate a frame interrupted by frame_sync (the remaining words are not sent) and start the new frame's word0 on the next cycle.
REQ-024 SHALL pulse ltncy_trig in the same cycle that word0 of a marker frame appears on tx_data.

Reset
REQ-025 SHALL, while reset_n is low, hold: tx_data=16'h0000, tx_isk=2'b00, ltncy_trig=0, strt_ltncy=0, phase=3, marker counter=0, LFSR=7'h7F, pending flags=0.
REQ-026 SHALL treat the first edge after reset_n deasserts as a load edge, so the first frame is a marker frame (FC) with strt_ltncy pulsed.
REQ-027 SHALL abandon any frame in progress when reset is asserted mid-frame; no partial word is emitted after reset.

Structure
REQ-028 SHALL place the K-character constants (BC, F7, FC), the frame word count (4) and the default MARKER_PERIOD in the shared trigger-link package.
REQ-029 SHALL implement the 56-step PRBS-7 as one sub-module, prbs7_gen56 (combinational next-state plus 56-bit output).

Verification
REQ-030 SHALL cover a basic frame: gem_data=56'h00112233445566, no overflow, non-marker frame -> tx_data BC66,4455,2233,0011 on consecutive cycles; isk 10,00,00,00.
REQ-031 SHALL cover the marker: after reset, frame 0 and frame 128 -> word0 K=FC, with ltncy_trig on both and strt_ltncy only on frame 0.
REQ-032 SHALL cover overflow on frame 128 -> frame 128 K=FC and frame 129 K=F7; overflow on frame 5 -> frame 5 K=F7.
REQ-033 SHALL cover inj_err: pulse twice within one frame, data=0 -> next frame word0=BC01, the frame after that =BC00.
REQ-034 SHALL cover frame_sync asserted while phase==1 -> words 2-3 of that frame dropped; the next cycle shows a new word0 with isk=10.
REQ-035 SHALL cover ena_test_pat=1 for 3 frames -> data matches a reference PRBS-7 model from seed 7F; with test pattern off, data passes unchanged.

Source files
------------

// File: rtl/trig_frame_formatter_pkg.sv
// rtl/trig_frame_formatter_pkg.sv - shared trigger-link constants
package trig_frame_formatter_pkg;

    localparam logic [7:0] K_BC = 8'hBC;
    localparam logic [7:0] K_F7 = 8'hF7;
    localparam logic [7:0] K_FC = 8'hFC;

    localparam int FRAME_WORDS           = 4;
    localparam int FRAME_BITS            = 56;
    localparam int DEFAULT_MARKER_PERIOD = 128;

    localparam logic [1:0] ISK_WORD0 = 2'b10;
    localparam logic [6:0] PRBS_SEED = 7'h7F;

endpackage

// File: rtl/trig_frame_formatter_prbs7_gen56.sv
// rtl/trig_frame_formatter_prbs7_gen56.sv - 56-step PRBS-7 (x^7+x^6+1), bit 0 generated first
module prbs7_gen56
    import trig_frame_formatter_pkg::*;
(
    input  logic [6:0]            i_state,
    output logic [6:0]            o_next,
    output logic [FRAME_BITS-1:0] o_bits
);

    logic [6:0] w_s;

    always_comb begin
        w_s    = i_state;
        o_bits = '0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            o_bits[i] = w_s[6] ^ w_s[5];
            w_s       = {w_s[5:0], w_s[6] ^ w_s[5]};
        end
        o_next = w_s;
    end

endmodule

// File: rtl/trig_frame_formatter.sv
// rtl/trig_frame_formatter.sv - packs 56-bit BX cluster frames into 4 x 16-bit GTX words
module trig_frame_formatter
    import trig_frame_formatter_pkg::*;
#(
    parameter int MARKER_PERIOD = DEFAULT_MARKER_PERIOD
)
(
    input  logic                  clk_160,
    input  logic                  reset_n,
    input  logic [FRAME_BITS-1:0] gem_data,
    input  logic                  gem_overflow,
    input  logic                  frame_sync,
    input  logic                  ena_test_pat,
    input  logic                  inj_err,
    output logic [15:0]           tx_data,
    output logic [1:0]            tx_isk,
    output logic                  ltncy_trig,
    output logic                  strt_ltncy
);

    localparam int             CW         = (MARKER_PERIOD > 1) ? $clog2(MARKER_PERIOD) : 1;
    localparam logic [CW-1:0]  MCNT_LAST  = CW'(MARKER_PERIOD - 1);
    localparam logic [1:0]     LAST_PHASE = 2'(FRAME_WORDS - 1);

    logic [1:0]            r_phase;
    logic [CW-1:0]         r_mcnt;
    logic [6:0]            r_lfsr;
    logic                  r_ovf_pend;
    logic                  r_inj_pend;
    logic                  r_inj_d;
    logic                  r_started;
    logic [FRAME_BITS-1:8] r_frame;
    logic [15:0]           r_tx_data;
    logic [1:0]            r_tx_isk;
    logic                  r_ltncy;
    logic                  r_strt;

    logic                  w_load;
    logic                  w_marker;
    logic                  w_inj_now;
    logic                  w_ovf_now;
    logic [6:0]            w_prbs_next;
    logic [FRAME_BITS-1:0] w_prbs_bits;
    logic [FRAME_BITS-1:0] w_data;
    logic [7:0]            w_k;

    prbs7_gen56 u_prbs (
        .i_state (r_lfsr),
        .o_next  (w_prbs_next),
        .o_bits  (w_prbs_bits)
    );

    assign w_load    = (r_phase == LAST_PHASE) || frame_sync;
    assign w_marker  = (r_mcnt == '0);
    // An inj_err edge on the load edge itself still lands in the frame being loaded.
    assign w_inj_now = r_inj_pend | (inj_err & ~r_inj_d);
    assign w_ovf_now = gem_overflow | r_ovf_pend;
    assign w_data    = (ena_test_pat ? w_prbs_bits : gem_data) ^ {{(FRAME_BITS-1){1'b0}}, w_inj_now};
    assign w_k       = w_marker ? K_FC : (w_ovf_now ? K_F7 : K_BC);

    always_ff @(posedge clk_160 or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= LAST_PHASE;
            r_mcnt     <= '0;
            r_lfsr     <= PRBS_SEED;
            r_ovf_pend <= 1'b0;
            r_inj_pend <= 1'b0;
            r_inj_d    <= 1'b0;
            r_started  <= 1'b0;
            r_frame    <= '0;
            r_tx_data  <= 16'h0000;
            r_tx_isk   <= 2'b00;
            r_ltncy    <= 1'b0;
            r_strt     <= 1'b0;
        end else begin
            r_inj_d <= inj_err;
            if (w_load) begin
                r_phase    <= 2'd0;
                r_frame    <= w_data[FRAME_BITS-1:8];
                r_mcnt     <= (r_mcnt == MCNT_LAST) ? '0 : r_mcnt + CW'(1);
                if (ena_test_pat) begin
                    r_lfsr <= w_prbs_next;
                end
                // Overflow hidden behind a marker K is carried to the next frame.
                r_ovf_pend <= w_marker & w_ovf_now;
                r_inj_pend <= 1'b0;
                r_started  <= 1'b1;
                r_tx_data  <= {w_k, w_data[7:0]};
                r_tx_isk   <= ISK_WORD0;
                r_ltncy    <= w_marker;
                r_strt     <= w_marker & ~r_started;
            end else begin
                r_phase    <= r_phase + 2'd1;
                r_inj_pend <= w_inj_now;
                r_tx_isk   <= 2'b00;
                r_ltncy    <= 1'b0;
                r_strt     <= 1'b0;
                case (r_phase)
                    2'd0:    r_tx_data <= r_frame[23:8];
                    2'd1:    r_tx_data <= r_frame[39:24];
                    2'd2:    r_tx_data <= r_frame[55:40];
                    default: r_tx_data <= 16'h0000;
                endcase
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_isk     = r_tx_isk;
    assign ltncy_trig = r_ltncy;
    assign strt_ltncy = r_strt;

endmodule

// File: tb/tb_trig_frame_formatter.sv
// tb/tb_trig_frame_formatter.sv - scoreboard bench with a frame-level reference model
`timescale 1ns/1ps
module tb_trig_frame_formatter;

    localparam int MP = 128;

    logic        clk_160 = 1'b0;
    logic        reset_n;
    logic [55:0] gem_data;
    logic        gem_overflow;
    logic        frame_sync;
    logic        ena_test_pat;
    logic        inj_err;
    logic [15:0] tx_data;
    logic [1:0]  tx_isk;
    logic        ltncy_trig;
    logic        strt_ltncy;

    trig_frame_formatter #(.MARKER_PERIOD(MP)) dut (
        .clk_160      (clk_160),
        .reset_n      (reset_n),
        .gem_data     (gem_data),
        .gem_overflow (gem_overflow),
        .frame_sync   (frame_sync),
        .ena_test_pat (ena_test_pat),
        .inj_err      (inj_err),
        .tx_data      (tx_data),
        .tx_isk       (tx_isk),
        .ltncy_trig   (ltncy_trig),
        .strt_ltncy   (strt_ltncy)
    );

    always #3 clk_160 = ~clk_160;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    logic        mon_en = 1'b0;

    // reference state
    int   frame_cnt;
    int   tp_idx;
    logic ovf_pend;
    logic inj_pend;
    logic inj_prev;
    logic sync_next;
    bit   seq[127];

    function automatic logic [55:0] rand56();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[55:0];
    endfunction

    function automatic logic [55:0] prbs_chunk(input int j);
        logic [55:0] r;
        for (int b = 0; b < 56; b++) r[b] = seq[(56 * j + b) % 127];
        return r;
    endfunction

    task automatic model_reset();
        frame_cnt = 0;
        tp_idx    = 0;
        ovf_pend  = 1'b0;
        inj_pend  = 1'b0;
        inj_prev  = 1'b0;
        sync_next = 1'b0;
    endtask

    task automatic sample_inj();
        if (inj_err && !inj_prev) inj_pend = 1'b1;
        inj_prev = inj_err;
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_tx_data", tx_data, 16'h0000);
        check_val("rst_tx_isk", {14'd0, tx_isk}, 16'h0000);
        check_val("rst_ltncy_trig", {15'd0, ltncy_trig}, 16'h0000);
        check_val("rst_strt_ltncy", {15'd0, strt_ltncy}, 16'h0000);
    endtask

    // inj_mode: 0 none, 1 random level each cycle, 2 two rising edges inside the frame
    task automatic send_frame(input logic [55:0] data, input logic ovf, input logic tp,
                              input int len, input int inj_mode);
        logic [55:0] d;
        logic [7:0]  k;
        logic        mk;
        logic        eff;
        logic [15:0] w[4];
        @(negedge clk_160);
        gem_data     = data;
        gem_overflow = ovf;
        ena_test_pat = tp;
        frame_sync   = sync_next;
        inj_err      = (inj_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk_160);
        sample_inj();
        mk = ((frame_cnt % MP) == 0);
        if (tp) begin
            d = prbs_chunk(tp_idx);
            tp_idx++;
        end else begin
            d = data;
        end
        if (inj_pend) d[0] = ~d[0];
        inj_pend = 1'b0;
        eff = ovf | ovf_pend;
        if (mk) begin
            k = 8'hFC;
            ovf_pend = eff;
        end else begin
            k = eff ? 8'hF7 : 8'hBC;
            ovf_pend = 1'b0;
        end
        w[0] = {k, d[7:0]};
        w[1] = d[23:8];
        w[2] = d[39:24];
        w[3] = d[55:40];
        for (int i = 0; i < len; i++)
            exp_q.push_back({w[i], (i == 0) ? 2'b10 : 2'b00, (i == 0) && mk, (i == 0) && mk && (frame_cnt == 0)});
        frame_cnt++;
        sync_next = (len < 4);
        for (int i = 1; i < len; i++) begin
            @(negedge clk_160);
            gem_data     = rand56();
            gem_overflow = 1'($urandom_range(0, 1));
            ena_test_pat = 1'($urandom_range(0, 1));
            frame_sync   = 1'b0;
            inj_err      = (inj_mode == 2) ? 1'(i % 2) :
                           (inj_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk_160);
            sample_inj();
        end
    endtask

    initial begin : monitor
        logic [19:0] e;
        forever begin
            @(negedge clk_160);
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({tx_data, tx_isk, ltncy_trig, strt_ltncy} !== e) begin
                    errors++;
                    $display("FAIL word actual data=%h isk=%b lt=%b st=%b required data=%h isk=%b lt=%b st=%b",
                             tx_data, tx_isk, ltncy_trig, strt_ltncy, e[19:4], e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit x[134];
        int len;
        for (int i = 0; i < 7; i++) x[i] = 1'b1;
        for (int n = 0; n < 127; n++) begin
            x[n + 7] = x[n] ^ x[n + 1];
            seq[n] = x[n + 7];
        end

        reset_n = 1'b0;
        gem_data = rand56();
        gem_overflow = 1'b1;
        frame_sync = 1'b0;
        ena_test_pat = 1'b1;
        inj_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_160);
        #1 check_reset_outputs();
        @(posedge clk_160);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        send_frame(rand56(), 1'b0, 1'b0, 4, 0);
        send_frame(56'h00112233445566, 1'b0, 1'b0, 4, 2);
        send_frame(56'h0, 1'b0, 1'b0, 4, 0);
        send_frame(56'h0, 1'b0, 1'b0, 2, 0);
        send_frame(rand56(), 1'b0, 1'b0, 4, 0);
        send_frame(rand56(), 1'b1, 1'b0, 4, 0);
        for (int n = 6; n < 9; n++) send_frame(rand56(), 1'b0, 1'b1, 4, 0);
        send_frame(rand56(), 1'b0, 1'b0, 4, 0);

        for (int n = 10; n < 140; n++) begin
            len = ($urandom_range(0, 7) < 5) ? 4 : $urandom_range(1, 3);
            send_frame(rand56(),
                       (n == 128) ? 1'b1 : (n == 129) ? 1'b0 : 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 3) == 0), len,
                       ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        send_frame(rand56(), 1'b1, 1'b1, 4, 0);
        send_frame(rand56(), 1'b0, 1'b0, 2, 0);
        @(negedge clk_160);
        #1 reset_n = 1'b0;
        mon_en = 1'b0;
        inj_err = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk_160);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        for (int n = 0; n < 8; n++)
            send_frame(rand56(), 1'($urandom_range(0, 1)), 1'(n % 2), 4, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_160);
        #1 check_val("drain", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
